// File: rtl/ddr_arb_pkg.sv
// Shared DDR write-arbiter definitions: bus width defaults, FSM encoding and
// the round-robin pointer helper.
`ifndef DDR_ADDR_W
`define DDR_ADDR_W 28
`endif
`ifndef DDR_DATA_W
`define DDR_DATA_W 256
`endif

package ddr_arb_pkg;

    localparam int DDR_ADDR_W_DEF = `DDR_ADDR_W;
    localparam int DDR_DATA_W_DEF = `DDR_DATA_W;
    localparam int TMO_CYC_DEF    = 1023;
    localparam int TMO_CNT_W      = 10;
    localparam int MAX_REQ        = 8;
    localparam int ID_W           = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_HOLD  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_ACK   = 3'd4
    } arb_state_e;

    // Pointer slot just after the given winner, wrapping at num_req.
    function automatic logic [ID_W-1:0] rr_advance(input logic [ID_W-1:0] id,
                                                   input int              num_req);
        if (int'(id) >= num_req - 1) begin
            return '0;
        end
        return id + 3'd1;
    endfunction

endpackage

// File: rtl/ddr_wr_arbiter_rr_pick.sv
// Round-robin winner search: first asserted request at or above rr_ptr,
// wrapping modulo NUM_REQ.
module rr_pick
    import ddr_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic               valid,
    output logic [ID_W-1:0]    winner
);

    logic [MAX_REQ-1:0] req_ext;

    assign req_ext = MAX_REQ'(req);

    // Scan from the farthest slot down so the slot nearest rr_ptr is written last.
    always_comb begin
        int              slot;
        logic [ID_W-1:0] idx;
        valid  = 1'b0;
        winner = '0;
        slot   = 0;
        idx    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            slot = int'(rr_ptr) + k;
            if (slot >= NUM_REQ) begin
                slot = slot - NUM_REQ;
            end
            idx = ID_W'(slot);
            if (req_ext[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/ddr_wr_arbiter.sv
// Round-robin arbiter feeding one DDR write controller: one burst in flight,
// rising-edge wr_req handshake, completion ack with timeout.
module ddr_wr_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = DDR_ADDR_W_DEF,
    parameter int DATA_W  = DDR_DATA_W_DEF,
    parameter int TMO_CYC = TMO_CYC_DEF
) (
    input  logic                      clk_100M,
    input  logic                      rstn,
    input  logic                      init_done,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*4-1:0]      req_len,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      ack_err,
    output logic [2:0]                grant_id,
    output logic                      busy,
    output logic                      wr_req,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [3:0]                awlen,
    output logic [DATA_W-1:0]         wr_data,
    input  logic                      wr_busy,
    input  logic                      wr_done,
    output logic                      err_sticky
);

    // The counter is cleared on ISSUE entry, so it holds TMO_CYC-1 in the
    // last cycle before the timeout takes effect on the following edge.
    localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TMO_CYC - 1);

    arb_state_e            state_q, state_d;
    logic [TMO_CNT_W-1:0]  cnt_q, cnt_d;
    logic [ID_W-1:0]       grant_id_q, grant_id_d;
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic                  tmo_q, tmo_d;
    logic                  sticky_q, sticky_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [3:0]            len_q, len_d;
    logic [DATA_W-1:0]     data_q, data_d;

    logic                  pick_valid;
    logic [ID_W-1:0]       pick_winner;
    logic                  tmo_hit;

    logic [ADDR_W-1:0]     addr_arr [MAX_REQ];
    logic [3:0]            len_arr  [MAX_REQ];
    logic [DATA_W-1:0]     data_arr [MAX_REQ];

    for (genvar i = 0; i < MAX_REQ; i++) begin : g_unpack
        if (i < NUM_REQ) begin : g_live
            assign addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
            assign len_arr[i]  = req_len[i*4 +: 4];
            assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
        end else begin : g_pad
            assign addr_arr[i] = '0;
            assign len_arr[i]  = '0;
            assign data_arr[i] = '0;
        end
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    always_ff @(posedge clk_100M) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            tmo_q      <= 1'b0;
            sticky_q   <= 1'b0;
            addr_q     <= '0;
            len_q      <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            tmo_q      <= tmo_d;
            sticky_q   <= sticky_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            data_q     <= data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        tmo_d      = tmo_q;
        sticky_d   = sticky_q;
        addr_d     = addr_q;
        len_d      = len_q;
        data_d     = data_q;
        wr_req     = 1'b0;
        busy       = 1'b0;
        ack        = '0;
        ack_err    = 1'b0;
        tmo_hit    = (cnt_q == TMO_LAST);

        case (state_q)
            ST_IDLE: begin
                // wr_req is low here, so every ISSUE starts a fresh rising edge.
                if (init_done && pick_valid && !wr_busy) begin
                    state_d    = ST_ISSUE;
                    cnt_d      = '0;
                    tmo_d      = 1'b0;
                    grant_id_d = pick_winner;
                    addr_d     = addr_arr[pick_winner];
                    len_d      = len_arr[pick_winner];
                    data_d     = data_arr[pick_winner];
                end
            end
            ST_ISSUE: begin
                wr_req = 1'b1;
                busy   = 1'b1;
                cnt_d  = cnt_q + TMO_CNT_W'(1);
                if (tmo_hit) begin
                    state_d  = ST_ACK;
                    tmo_d    = 1'b1;
                    sticky_d = 1'b1;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                wr_req = 1'b1;
                busy   = 1'b1;
                cnt_d  = cnt_q + TMO_CNT_W'(1);
                if (tmo_hit) begin
                    state_d  = ST_ACK;
                    tmo_d    = 1'b1;
                    sticky_d = 1'b1;
                end else if (wr_busy) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                busy  = 1'b1;
                cnt_d = cnt_q + TMO_CNT_W'(1);
                // A completion in the timeout cycle still counts as success.
                if (wr_done) begin
                    state_d  = ST_ACK;
                    tmo_d    = 1'b0;
                    rr_ptr_d = rr_advance(grant_id_q, NUM_REQ);
                end else if (tmo_hit) begin
                    state_d  = ST_ACK;
                    tmo_d    = 1'b1;
                    sticky_d = 1'b1;
                end
            end
            ST_ACK: begin
                busy    = 1'b1;
                ack_err = tmo_q;
                for (int i = 0; i < NUM_REQ; i++) begin
                    ack[i] = (grant_id_q == ID_W'(i));
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign grant_id   = grant_id_q;
    assign wr_addr    = addr_q;
    assign awlen      = len_q;
    assign wr_data    = data_q;
    assign err_sticky = sticky_q;

endmodule

// File: doc/ddr_wr_arbiter.md
DDR_WR_ARBITER -- requirements
Module: ddr_wr_arbiter

Interface
REQ-001 SHALL have parameters:
- NUM_REQ, default 4: number of requesters, 2..8.
- ADDR_W, default 28: DDR address width.
- DATA_W, default 256: data beat width.
- TMO_CYC, default 1023: cycles allowed from issue to wr_done.

REQ-002 SHALL use reset rstn, synchronous, active-low, and clock clk_100M.

REQ-003 SHALL have these ports (name, direction, width, meaning):
- clk_100M, in, 1: clock.
- rstn, in, 1: reset.
- init_done, in, 1: DDR calibration complete.
- req, in, NUM_REQ: per-requester level request, held until its ack.
- req_addr, in, NUM_REQ*ADDR_W: packed addresses; requester i occupies slice [i*ADDR_W +: ADDR_W].
- req_len, in, NUM_REQ*4: packed burst lengths.
- req_data, in, NUM_REQ*DATA_W: packed write data.
- ack, out, NUM_REQ: one-cycle completion pulse to the granted requester.
- ack_err, out, 1: qualifies ack; 1 means the transfer timed out.
- grant_id, out, 3: index of the current or last granted requester.
- busy, out, 1: a transfer is in flight.
- wr_req, out, 1: to the write controller; the controller samples its rising edge.
- wr_addr, out, ADDR_W: write address to the controller.
- awlen, out, 4: burst length to the controller.
- wr_data, out, DATA_W: write data to the controller.
- wr_busy, in, 1: controller busy.
- wr_done, in, 1: controller completion pulse.
- err_sticky, out, 1: latched timeout flag.

Function
REQ-004 SHALL implement an FSM with states IDLE, ISSUE, HOLD, WAIT and ACK.
REQ-005 IDLE -> ISSUE SHALL occur when init_done=1 and req!=0 and wr_busy=0; in that cycle the block latches the winner, its addr, len and data into the wr_addr/awlen/wr_data registers, and sets grant_id.
REQ-006 Arbitration SHALL be round-robin. The search starts at pointer rr_ptr; the first asserted req at or above rr_ptr wins, wrapping modulo NUM_REQ.
REQ-007 rr_ptr SHALL update to (winner+1) mod NUM_REQ on entry to ACK only; it is unchanged on timeout.
REQ-008 ISSUE SHALL drive wr_req=1, with wr_req having been 0 in the prior cycle so a rising edge is guaranteed; the FSM moves to HOLD next cycle.
REQ-009 HOLD SHALL keep wr_req=1 until wr_busy=1 is sampled, then drop wr_req to 0 and move to WAIT.
REQ-010 WAIT SHALL move to ACK on wr_done=1.
REQ-011 In ACK (one cycle), ack[grant_id] SHALL be 1, busy SHALL be 0 on the next cycle, and the FSM returns to IDLE.
REQ-012 The minimum gap between successive wr_req rising edges SHALL be 2 cycles, because IDLE forces wr_req=0.
REQ-013 A 10-bit timeout counter SHALL clear on entry to ISSUE and increment in ISSUE, HOLD and WAIT. When it reaches TMO_CYC, the block drops wr_req, goes to ACK with ack_err=1, and sets err_sticky.
REQ-014 err_sticky SHALL clear only on reset.
REQ-015 wr_done arriving in IDLE SHALL be ignored, with no ack.
REQ-016 wr_done and timeout in the same cycle: wr_done SHALL win, so ack_err=0.
REQ-017 A requester dropping req after grant SHALL NOT abort the transfer; the ack is still issued.
REQ-018 init_done falling mid-transfer SHALL NOT abort the transfer; no new grant occurs while init_done=0.
REQ-019 busy SHALL be 1 in ISSUE, HOLD, WAIT and ACK.
REQ-020 wr_addr, awlen and wr_data SHALL be stable from ISSUE through ACK.

Reset
REQ-021 On rstn=0 at a clock edge, the block SHALL set: state=IDLE, wr_req=0, ack=0, ack_err=0, busy=0, err_sticky=0, grant_id=0, rr_ptr=0, counter=0, wr_addr=0, awlen=0, wr_data=0.
REQ-022 Reset mid-transfer SHALL abandon the transfer with no ack.

Structure
REQ-023 FSM state encodings, the TMO_CYC default, and the ADDR_W/DATA_W defaults SHALL live in shared package ddr_arb_pkg, alongside the existing DDR width macros.
REQ-024 The round-robin winner/pointer logic SHALL be the sub-module rr_pick (inputs: req, rr_ptr; outputs: valid, winner).

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Single requester: req=4'b0100, addr=0x0001000, len=3, and a model that asserts wr_busy 1 cycle after the wr_req rise and wr_done 8 cycles later -> wr_addr=0x0001000, awlen=3, ack=4'b0100 pulse, grant_id=2, ack_err=0.
- Fairness: req=4'b1111 held for 8 transfers -> grant order 0,1,2,3,0,1,2,3.
- Timeout: model never asserts wr_done -> ack pulse with ack_err=1 at 1023 cycles after ISSUE entry, err_sticky=1, rr_ptr unchanged.
- Init gating: init_done=0 with req=4'b0001 -> wr_req stays 0; init_done rises -> ISSUE within 1 cycle.
- Collision and spurious done: wr_done and timeout in the same cycle -> ack_err=0; a wr_done pulse in IDLE -> no ack.
- Mid-transfer reset: rstn=0 during WAIT -> all outputs take reset values next cycle, with no ack.
